// File: rtl/xpmwrap_pkg.sv
// Shared types and defaults for the xpmwrap SDPRAM helper blocks.
package xpmwrap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } rd_state_t;

  localparam int XPM_RD_LATENCY = 2;

endpackage

// File: rtl/xpmwrap_sdpram_stream_reader_if.sv
// Command and output-stream bundle of the SDPRAM stream reader.
// master: the reader (accepts commands, produces the stream).
// slave: the command source / stream consumer.
interface xpmwrap_sdpram_stream_reader_if #(
  parameter int ADDR_WIDTH_B      = 6,
  parameter int READ_DATA_WIDTH_B = 32
);
  logic [ADDR_WIDTH_B-1:0]      cmd_addr;
  logic [ADDR_WIDTH_B:0]        cmd_len;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [READ_DATA_WIDTH_B-1:0] m_tdata;
  logic                         m_tvalid;
  logic                         m_tlast;
  logic                         m_tready;

  modport master (
    input  cmd_addr, cmd_len, cmd_valid, m_tready,
    output cmd_ready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid, m_tready,
    input  cmd_ready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/xpmwrap_sync_fifo.sv
// Small synchronous FIFO; head entry and occupancy come straight from registers.
module xpmwrap_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_rd   = rd_en && valid;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; writers guarantee no write when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/xpmwrap_sdpram_stream_reader.sv
// Read-side controller for the byte-write SDPRAM: turns (addr, len) commands
// into port-B reads and streams the words out with tlast, credit-limited so
// the output FIFO absorbs the RAM read latency without overflowing.
module xpmwrap_sdpram_stream_reader
  import xpmwrap_pkg::*;
#(
  parameter int ADDR_WIDTH_B      = 6,
  parameter int READ_DATA_WIDTH_B = 32,
  parameter int READ_LATENCY_B    = XPM_RD_LATENCY,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clkb,
  input  logic                         rstb,
  xpmwrap_sdpram_stream_reader_if.master sif,
  output logic                         enb,
  output logic [ADDR_WIDTH_B-1:0]      addrb,
  output logic                         regceb,
  output logic                         ram_rstb,
  input  logic [READ_DATA_WIDTH_B-1:0] doutb,
  output logic                         busy,
  output logic                         done
);
  localparam int LAT   = READ_LATENCY_B;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_t               state_q;
  rd_state_t               state_d;
  logic [ADDR_WIDTH_B-1:0] addr_q;
  logic [ADDR_WIDTH_B:0]   left_q;
  logic [LAT-1:0]          pipe_q;
  logic [LAT-1:0]          last_q;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_valid;
  logic [READ_DATA_WIDTH_B:0] fifo_rd;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    accept;
  logic                    last_beat;

  assign regceb   = 1'b1;
  assign ram_rstb = rstb;
  assign addrb    = addr_q;
  assign enb      = issue;

  assign inflight   = CNT_W'($countones(pipe_q));
  // Registered counts only: a pop in this cycle does not free a credit yet.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign issue_last = issue && (left_q == (ADDR_WIDTH_B + 1)'(1));
  assign last_beat  = fifo_valid && sif.m_tready && sif.m_tlast;

  assign sif.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

  // Next-state and issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = sif.cmd_valid;
        if (sif.cmd_valid) begin
          state_d = (sif.cmd_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        issue = credit_ok;
        if (issue && (left_q == (ADDR_WIDTH_B + 1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, address/length counters and the in-flight flag/tag pipes.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      pipe_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= sif.cmd_addr;
        left_q <= sif.cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        left_q <= left_q - 1'b1;
      end
      pipe_q <= (pipe_q << 1) | LAT'(issue);
      last_q <= (last_q << 1) | LAT'(issue_last);
    end
  end

  xpmwrap_sync_fifo #(
    .WIDTH (READ_DATA_WIDTH_B + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clkb),
    .rst     (rstb),
    .wr_en   (pipe_q[LAT-1]),
    .wr_data ({last_q[LAT-1], doutb}),
    .rd_en   (sif.m_tready),
    .rd_data (fifo_rd),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign sif.m_tvalid = fifo_valid;
  assign sif.m_tlast  = fifo_rd[READ_DATA_WIDTH_B];
  assign sif.m_tdata  = fifo_rd[READ_DATA_WIDTH_B-1:0];
endmodule

// File: tb/tb_xpmwrap_sdpram_stream_reader.sv
// Scoreboard bench for xpmwrap_sdpram_stream_reader with a behavioural
// latency-2 port-B RAM.
module tb_xpmwrap_sdpram_stream_reader;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int WORDS = 64;

  logic          clkb = 1'b0;
  logic          rstb;
  logic          enb;
  logic [AW-1:0] addrb;
  logic          regceb;
  logic          ram_rstb;
  logic [DW-1:0] doutb;
  logic          busy;
  logic          done;

  xpmwrap_sdpram_stream_reader_if #(.ADDR_WIDTH_B(AW), .READ_DATA_WIDTH_B(DW)) sif ();

  xpmwrap_sdpram_stream_reader #(
    .ADDR_WIDTH_B      (AW),
    .READ_DATA_WIDTH_B (DW),
    .READ_LATENCY_B    (2),
    .FIFO_DEPTH        (4)
  ) dut (
    .clkb     (clkb),
    .rstb     (rstb),
    .sif      (sif.master),
    .enb      (enb),
    .addrb    (addrb),
    .regceb   (regceb),
    .ram_rstb (ram_rstb),
    .doutb    (doutb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clkb = ~clkb;

  // RAM port B model: address register stage then output register stage.
  logic [DW-1:0] ram [WORDS];
  logic [DW-1:0] ram_r1;
  always @(posedge clkb) begin
    if (ram_rstb) begin
      ram_r1 <= '0;
      doutb  <= '0;
    end else begin
      if (enb) ram_r1 <= ram[addrb];
      if (regceb) doutb <= ram_r1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clkb) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected progress (cycle %0d)", name, cyc);
  endtask

  // Ready generator: 0 always ready, 1 pattern 1,0,0,1 then random, 2 never, 3 random.
  int       ready_mode = 0;
  int       pat_idx = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clkb) begin
    #1;
    case (ready_mode)
      0: sif.m_tready = 1'b1;
      1: begin
        sif.m_tready = (pat_idx < 4) ? pat[pat_idx] : 1'($urandom_range(0, 1));
        pat_idx++;
      end
      2: sif.m_tready = 1'b0;
      default: sif.m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard state.
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_exp[$];
  logic          first_pending = 1'b0;
  logic          done_pending = 1'b0;
  logic          ready_chk = 1'b0;
  int            acc_cyc, exp_done_cyc, ready_chk_cyc;
  int            beats_in_cmd = 0;
  int            enb_total = 0;
  int            fifo_over = 0;
  logic          hold_prev = 1'b0;
  logic [DW+1:0] prev_out;
  logic [DW:0]   e;
  logic          done_now;

  // Monitor: expectations are pushed at command accept, popped on each beat/issue.
  always @(negedge clkb) begin
    if (rstb) begin
      exp_q.delete();
      addr_exp.delete();
      first_pending = 1'b0;
      done_pending  = 1'b0;
      ready_chk     = 1'b0;
      hold_prev     = 1'b0;
      beats_in_cmd  = 0;
    end else begin
      if (int'(dut.fifo_count) > 4) fifo_over++;
      if (enb) begin
        enb_total++;
        if (addr_exp.size() == 0) check("enb_unexpected", 1, 0);
        else check("addrb", addrb, addr_exp.pop_front());
      end
      if (sif.cmd_valid && sif.cmd_ready) begin
        check("accept_after_done", {exp_q.size() == 0, done_pending}, 2'b10);
        for (int k = 0; k < int'(sif.cmd_len); k++) begin
          exp_q.push_back({k == int'(sif.cmd_len) - 1, ram[(int'(sif.cmd_addr) + k) % WORDS]});
          addr_exp.push_back(AW'((int'(sif.cmd_addr) + k) % WORDS));
        end
        if (sif.cmd_len == 0) begin
          done_pending = 1'b1;
          exp_done_cyc = cyc + 1;
        end else begin
          first_pending = 1'b1;
          acc_cyc = cyc;
        end
        beats_in_cmd = 0;
      end
      if (first_pending && sif.m_tvalid) begin
        check("first_latency", cyc - acc_cyc, 4);
        first_pending = 1'b0;
      end
      if (ready_mode == 0 && beats_in_cmd > 0 && exp_q.size() > 0)
        check("no_bubble", sif.m_tvalid, 1);
      if (hold_prev)
        check("stall_stable", {sif.m_tvalid, sif.m_tlast, sif.m_tdata}, prev_out);
      hold_prev = sif.m_tvalid && !sif.m_tready;
      prev_out  = {sif.m_tvalid, sif.m_tlast, sif.m_tdata};
      if (sif.m_tvalid && sif.m_tready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", {sif.m_tlast, sif.m_tdata}, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {sif.m_tlast, sif.m_tdata}, e);
          beats_in_cmd++;
          if (e[DW]) begin
            done_pending = 1'b1;
            exp_done_cyc = cyc + 1;
          end
        end
      end
      done_now = done_pending && (cyc == exp_done_cyc);
      if (done_now) check("done_busy", {done, busy}, 2'b10);
      else if (done) check("done_spurious", done, 0);
      if (ready_chk && cyc == ready_chk_cyc) begin
        check("cmd_ready_after_done", sif.cmd_ready, 1);
        ready_chk = 1'b0;
      end
      if (done_now) begin
        done_pending  = 1'b0;
        ready_chk     = 1'b1;
        ready_chk_cyc = cyc + 1;
      end
    end
  end

  task automatic send_cmd(input int addr, input int len);
    bit ok = 0;
    @(posedge clkb); #1;
    sif.cmd_valid = 1'b1;
    sif.cmd_addr  = AW'(addr);
    sif.cmd_len   = (AW + 1)'(len);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clkb);
      if (sif.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("cmd_accept_timeout");
    @(posedge clkb); #1;
    sif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clkb);
      if (exp_q.size() == 0 && !done_pending && !ready_chk && !first_pending && sif.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  initial begin
    int base, r, len;
    bit ok;
    rstb = 1'b1;
    sif.cmd_valid = 1'b0;
    sif.cmd_addr  = '0;
    sif.cmd_len   = '0;
    sif.m_tready  = 1'b1;
    for (int i = 0; i < WORDS; i++) ram[i] = DW'(i);
    repeat (3) @(posedge clkb);
    #1 rstb = 1'b0;
    @(negedge clkb);
    check("reset_ctrl", {sif.cmd_ready, enb, busy, done, sif.m_tvalid, sif.m_tlast}, 6'b100000);
    check("reset_addrb", addrb, 0);
    check("reset_tdata", sif.m_tdata, 0);

    ready_mode = 0;
    send_cmd(5, 4);   wait_idle();
    send_cmd(62, 4);  wait_idle();
    pat_idx = 0; ready_mode = 1;
    send_cmd(10, 16); wait_idle();
    ready_mode = 0;
    send_cmd(3, 0);   wait_idle();

    // Abort with reads in flight and the stream stalled.
    ready_mode = 2;
    base = enb_total;
    send_cmd(20, 8);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkb);
      if (enb_total >= base + 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("inflight_timeout");
    @(posedge clkb); #1 rstb = 1'b1;
    @(posedge clkb); #1 rstb = 1'b0;
    @(negedge clkb);
    check("rst_abort", {sif.m_tvalid, busy, sif.cmd_ready}, 3'b001);
    ready_mode = 0;
    send_cmd(0, 2);   wait_idle();

    // Second command held off while the first runs.
    send_cmd(40, 6);
    send_cmd(50, 3);
    wait_idle();

    send_cmd(0, 64);  wait_idle();
    send_cmd(37, 64); wait_idle();

    for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
    for (int n = 0; n < 20; n++) begin
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      r = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? 64 : $urandom_range(1, 20);
      send_cmd($urandom_range(0, WORDS - 1), len);
      wait_idle();
    end
    ready_mode = 0;

    check("fifo_never_over_depth", fifo_over, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
